// File: rtl/hs_io_pkg.sv
// hs_io_pkg: state encoding, default sizing and beat-count helpers shared by hs_stream_io.
package hs_io_pkg;
  typedef enum logic [2:0] {IDLE, LD_REQ, LD_REL, WAIT_HASH, UL_REQ, UL_REL} hs_state_t;
  localparam int DEF_BUS_W = 8;
  localparam int DEF_HDR_BITS = 640;
  localparam int DEF_HASH_BITS = 256;
  localparam int DEF_TIMEOUT_CYC = 1024;
  function automatic int beats(input int bits, input int bus_w);
    return bits / bus_w;
  endfunction
  function automatic int cnt_w(input int hdr_bits, input int hash_bits, input int bus_w);
    return $clog2((hdr_bits > hash_bits ? hdr_bits : hash_bits) / bus_w) + 1;
  endfunction
endpackage

// File: rtl/hs_beat_port.sv
// hs_beat_port: four-phase rq/rdy beat sequencing; defining HS_WATCHDOG_EN adds a stall watchdog.
module hs_beat_port import hs_io_pkg::*; #(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic req_next,
  input  logic rel,
  input  logic rdy,
  output logic rq,
  output logic beat_ack,
  output logic beat_go,
  output logic timeout
);
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rq <= 1'b0;
    else rq <= req_next;
  end
  assign beat_ack = rq & rdy;
  assign beat_go = rel & ~rdy;
`ifdef HS_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;
  // counts cycles spent in one handshake phase; any phase change restarts it
  assign timeout = (rq || rel) && wd == WD_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd <= '0;
    else wd <= (!(rq || rel) || beat_ack || beat_go || timeout) ? '0 : wd + WD_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/hs_stream_io.sv
// hs_stream_io: loads a header over four-phase rq/rdy, then streams the hash back MSB-first.
// Optional handshake watchdog: define HS_WATCHDOG_EN.
module hs_stream_io import hs_io_pkg::*; #(
  parameter int BUS_W = DEF_BUS_W,
  parameter int HDR_BITS = DEF_HDR_BITS,
  parameter int HASH_BITS = DEF_HASH_BITS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BUS_W-1:0]     din,
  input  logic                 rdy,
  output logic                 rq,
  output logic [BUS_W-1:0]     dout,
  output logic                 done,
  output logic [HDR_BITS-1:0]  hdr,
  output logic                 hdr_valid,
  input  logic [HASH_BITS-1:0] hash_in,
  input  logic                 hash_valid,
  output logic                 err
);
  localparam int HDR_BEATS = beats(HDR_BITS, BUS_W);
  localparam int HASH_BEATS = beats(HASH_BITS, BUS_W);
  localparam int CNT_W = cnt_w(HDR_BITS, HASH_BITS, BUS_W);
  if (HDR_BITS % BUS_W != 0 || HASH_BITS % BUS_W != 0) begin : g_bad_width
    $error("HDR_BITS and HASH_BITS must be multiples of BUS_W");
  end
  hs_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [HASH_BITS-1:0] sreg;
  logic beat_ack, beat_go, timeout, kill;
  hs_beat_port #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_port (
    .clk      (clk),
    .rst      (rst),
    .req_next (state_n == LD_REQ || state_n == UL_REQ),
    .rel      (state == LD_REL || state == UL_REL),
    .rdy      (rdy),
    .rq       (rq),
    .beat_ack (beat_ack),
    .beat_go  (beat_go),
    .timeout  (timeout)
  );
  // abort and watchdog expiry share one exit path and take priority over rdy
  assign kill = state != IDLE && (abort || timeout);
  assign done = state == UL_REQ || state == UL_REL;
  assign dout = sreg[HASH_BITS-1 -: BUS_W];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? LD_REQ : IDLE;
      LD_REQ:    state_n = beat_ack ? LD_REL : LD_REQ;
      LD_REL:    state_n = !beat_go ? LD_REL : cnt == CNT_W'(HDR_BEATS) ? WAIT_HASH : LD_REQ;
      WAIT_HASH: state_n = hash_valid ? UL_REQ : WAIT_HASH;
      UL_REQ:    state_n = beat_ack ? UL_REL : UL_REQ;
      UL_REL:    state_n = !beat_go ? UL_REL : cnt == CNT_W'(HASH_BEATS) ? IDLE : UL_REQ;
      default:   state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hdr <= '0;
      sreg <= '0;
      hdr_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      hdr_valid <= state == LD_REL && state_n == WAIT_HASH;
      err <= kill;
      if ((state == IDLE && state_n == LD_REQ) || (state == WAIT_HASH && state_n == UL_REQ)) cnt <= '0;
      else if (beat_ack && !kill) cnt <= cnt + CNT_W'(1);
      if (state == LD_REQ && state_n == LD_REL) hdr <= {hdr[HDR_BITS-BUS_W-1:0], din};
      if (state == WAIT_HASH && state_n == UL_REQ) sreg <= hash_in;
      else if (state == UL_REQ && state_n == UL_REL) sreg <= {sreg[HASH_BITS-BUS_W-1:0], {BUS_W{1'b0}}};
    end
  end
endmodule

// File: tb/tb_hs_stream_io.sv
// tb_hs_stream_io: directed checks of hs_stream_io at BUS_W=8 (TIMEOUT_CYC=16) and BUS_W=32.
module tb_hs_stream_io;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start_a = 0, abort_a = 0, rdy_a = 0, hvin_a = 0, rq_a, done_a, hv_a, err_a;
  logic [7:0] din_a = '0, dout_a;
  logic [639:0] hdr_a;
  logic [255:0] hash_a = '0;
  logic start_b = 0, abort_b = 0, rdy_b = 0, hvin_b = 0, rq_b, done_b, hv_b, err_b;
  logic [31:0] din_b = '0, dout_b;
  logic [639:0] hdr_b;
  logic [255:0] hash_b = '0;
  hs_stream_io #(.BUS_W(8), .HDR_BITS(640), .HASH_BITS(256), .TIMEOUT_CYC(16)) ua (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .din(din_a), .rdy(rdy_a), .rq(rq_a),
    .dout(dout_a), .done(done_a), .hdr(hdr_a), .hdr_valid(hv_a), .hash_in(hash_a),
    .hash_valid(hvin_a), .err(err_a));
  hs_stream_io #(.BUS_W(32), .HDR_BITS(640), .HASH_BITS(256), .TIMEOUT_CYC(1024)) ub (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .din(din_b), .rdy(rdy_b), .rq(rq_b),
    .dout(dout_b), .done(done_b), .hdr(hdr_b), .hdr_valid(hv_b), .hash_in(hash_b),
    .hash_valid(hvin_b), .err(err_b));
  int rises_a = 0, rises_b = 0, hvc_a = 0, hvc_b = 0, donec_a = 0, errc_a = 0;
  logic rqp_a = 0, rqp_b = 0;
  always @(posedge clk) begin
    rqp_a <= rq_a;
    rqp_b <= rq_b;
    if (rq_a && !rqp_a) rises_a <= rises_a + 1;
    if (rq_b && !rqp_b) rises_b <= rises_b + 1;
    if (hv_a) hvc_a <= hvc_a + 1;
    if (hv_b) hvc_b <= hvc_b + 1;
    if (done_a) donec_a <= donec_a + 1;
    if (err_a) errc_a <= errc_a + 1;
  end
  int checks = 0, errors = 0;
  logic [639:0] hdr_ref, rot_ref;
  logic [255:0] hash_ref, got;
  logic done_mid;
  int base_r, base_hv, base_d, base_e;
  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input bit b);
    if (b) start_b = 1; else start_a = 1;
    step();
    if (b) start_b = 0; else start_a = 0;
  endtask
  task automatic wait_rq(input bit b);
    for (int k = 0; k < 20 && !(b ? rq_b : rq_a); k++) step();
    check("rq_wait", b ? rq_b : rq_a, 1);
  endtask
  task automatic load(input bit b, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      wait_rq(b);
      if (b) din_b = hdr_ref[639 - 32*i -: 32]; else din_a = hdr_ref[639 - 8*i -: 8];
      if (b) rdy_b = 1; else rdy_a = 1;
      step();
      if (b) rdy_b = 0; else rdy_a = 0;
      step();
    end
  endtask
  task automatic unload(input bit b);
    int n = b ? 8 : 32;
    got = '0;
    done_mid = 0;
    for (int i = 0; i < n; i++) begin
      wait_rq(b);
      got = b ? {got[223:0], dout_b} : {got[247:0], dout_a};
      if (b) rdy_b = 1; else rdy_a = 1;
      step();
      done_mid = b ? done_b : done_a;
      if (b) rdy_b = 0; else rdy_a = 0;
      step();
    end
  endtask
  initial begin
    hdr_ref = {32'h01000000, 256'h0,
               256'h3BA3EDFD7A7B12B27AC72C3E67768F617FC81BC3888A51323A9FB8AA4B1E5E4A,
               32'h29AB5F49, 32'hFFFF001D, 32'h1DAC2B7C};
    hash_ref = 256'h6FE28C0AB6F1B372C1A6A246AE63F74F931E8365E15A089C68D6190000000000;
    rot_ref = (hdr_ref << 312) | (hdr_ref >> 328);
    step();
    step();
    rst = 0;
    step();
    check("rst_rq", rq_a, 0);
    check("rst_done", done_a, 0);
    check("rst_hv", hv_a, 0);
    check("rst_err", err_a, 0);
    check("rst_dout", dout_a, 0);
    check("rst_hdr", hdr_a, 0);
    // 8-bit load of the genesis header
    base_r = rises_a; base_hv = hvc_a; base_d = donec_a;
    kick(0);
    check("rq_after_start", rq_a, 1);
    load(0, 0, 80);
    check("hv_pulse", hv_a, 1);
    check("hdr8", hdr_a, hdr_ref);
    check("wait_rq_low", rq_a, 0);
    step();
    check("hv_one_cycle", hv_a, 0);
    check("hv_count8", hvc_a - base_hv, 1);
    check("ld_beats8", rises_a - base_r, 80);
    check("done_low_load", donec_a - base_d, 0);
    hvin_a = 1; hash_a = hash_ref;
    step();
    hvin_a = 0;
    check("done_rise", done_a, 1);
    check("ul_rq", rq_a, 1);
    check("dout_first", dout_a, 8'h6F);
    base_r = rises_a;
    unload(0);
    check("hash8", got, hash_ref);
    check("done_last_beat", done_mid, 1);
    check("done_fall", done_a, 0);
    check("ul_idle_rq", rq_a, 0);
    check("ul_beats8", rises_a - base_r, 32);
    // abort on load beat 40 together with rdy
    base_hv = hvc_a; base_e = errc_a;
    kick(0);
    load(0, 0, 39);
    wait_rq(0);
    din_a = hdr_ref[639 - 8*39 -: 8];
    rdy_a = 1; abort_a = 1;
    step();
    rdy_a = 0; abort_a = 0;
    check("abort_err", err_a, 1);
    check("abort_rq", rq_a, 0);
    check("abort_done", done_a, 0);
    check("abort_hdr_kept", hdr_a, rot_ref);
    step();
    check("abort_err_pulse", err_a, 0);
    check("abort_idle_rq", rq_a, 0);
    check("abort_no_hv", hvc_a - base_hv, 0);
    check("abort_err_cnt", errc_a - base_e, 1);
    kick(0);
    load(0, 0, 80);
    check("restart_hv", hv_a, 1);
    check("restart_hdr", hdr_a, hdr_ref);
    abort_a = 1;
    step();
    abort_a = 0;
    check("abort_wait_err", err_a, 1);
    check("abort_wait_done", done_a, 0);
    step();
    // rdy held high after the ack; start/hash_valid during load are ignored
    base_r = rises_a;
    kick(0);
    wait_rq(0);
    din_a = hdr_ref[639 -: 8];
    rdy_a = 1;
    step();
    check("held_rq1", rq_a, 0);
    start_a = 1; hvin_a = 1; hash_a = '1;
    step();
    check("held_rq2", rq_a, 0);
    start_a = 0; hvin_a = 0;
    step();
    check("held_rq3", rq_a, 0);
    rdy_a = 0;
    step();
    check("held_release_rq", rq_a, 1);
    load(0, 1, 79);
    check("held_hv", hv_a, 1);
    check("held_hdr", hdr_a, hdr_ref);
    check("held_beats", rises_a - base_r, 80);
    hvin_a = 1; hash_a = hash_ref;
    step();
    hvin_a = 0;
    unload(0);
    check("held_hash", got, hash_ref);
    // 32-bit instance
    base_r = rises_b; base_hv = hvc_b;
    kick(1);
    check("b_rq_after_start", rq_b, 1);
    load(1, 0, 20);
    check("b_hv", hv_b, 1);
    check("b_hdr", hdr_b, hdr_ref);
    check("b_done_low", done_b, 0);
    step();
    check("b_hv_count", hvc_b - base_hv, 1);
    check("b_ld_beats", rises_b - base_r, 20);
    hvin_b = 1; hash_b = hash_ref;
    step();
    hvin_b = 0;
    check("b_done_rise", done_b, 1);
    check("b_dout_first", dout_b, 32'h6FE28C0A);
    base_r = rises_b;
    unload(1);
    check("b_hash", got, hash_ref);
    check("b_done_last_beat", done_mid, 1);
    check("b_done_fall", done_b, 0);
    check("b_ul_beats", rises_b - base_r, 8);
    // host goes silent after load beat 5
    base_e = errc_a;
    kick(0);
    load(0, 0, 5);
    check("silent_rq", rq_a, 1);
`ifdef HS_WATCHDOG_EN
    repeat (15) step();
    check("wd_before_err", err_a, 0);
    check("wd_before_rq", rq_a, 1);
    step();
    check("wd_err", err_a, 1);
    check("wd_rq", rq_a, 0);
    check("wd_done", done_a, 0);
    step();
    check("wd_err_pulse", err_a, 0);
    check("wd_idle_rq", rq_a, 0);
`else
    repeat (100) step();
    check("nowd_rq_held", rq_a, 1);
    check("nowd_no_err", errc_a - base_e, 0);
    abort_a = 1;
    step();
    abort_a = 0;
    check("nowd_abort_err", err_a, 1);
    check("nowd_abort_rq", rq_a, 0);
    step();
`endif
    // asynchronous reset in the middle of a load
    kick(0);
    load(0, 0, 3);
    wait_rq(0);
    #2;
    rst = 1;
    #1;
    check("arst_rq", rq_a, 0);
    check("arst_hdr", hdr_a, 0);
    check("arst_done", done_a, 0);
    step();
    rst = 0;
    step();
    check("arst_idle_rq", rq_a, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hs_stream_io.md
Name: hs_stream_io

Overview:
- Parametrised host-side streaming engine for the mining core.
- Loads a block header from the host over a four-phase rq/rdy handshake, presents it to the hash core, then streams the resulting hash back out, MSB-first, over the same handshake.
- Successor to the fixed 8-bit, 640-bit-in / 256-bit-out loader; generalised in bus width and frame sizes.
- Adds an abort path and optional handshake watchdog.

Parameters:
- BUS_W, 8, data bits per handshake beat; HDR_BITS and HASH_BITS must be multiples of BUS_W.
- HDR_BITS, 640, header bits loaded per job.
- HASH_BITS, 256, hash bits returned per job.
- TIMEOUT_CYC, 1024, watchdog limit in clk cycles (used only with HS_WATCHDOG_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE only.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- din  in  BUS_W  host data during load.
- rdy  in  1  host acknowledge, synchronous to clk.
- rq  out  1  beat request to host.
- dout  out  BUS_W  hash beat during unload.
- done  out  1  high throughout the unload phase.
- hdr  out  HDR_BITS  assembled header, MSB = first beat.
- hdr_valid  out  1  one-cycle pulse when the header is complete.
- hash_in  in  HASH_BITS  result from the core.
- hash_valid  in  1  one-cycle pulse; captures hash_in.
- err  out  1  one-cycle pulse on abort or timeout.

Behaviour:
- Reset values: rq=0, done=0, hdr_valid=0, err=0, dout=0, hdr=0, beat counter=0, state=IDLE.
- States: IDLE, LD_REQ, LD_REL, WAIT_HASH, UL_REQ, UL_REL.
- IDLE:
  - start=1 -> LD_REQ, counter cleared.
  - hash_valid ignored.
- LD_REQ:
  - rq=1.
  - When rdy=1, shift din into hdr from the top (hdr <= {hdr[HDR_BITS-BUS_W-1:0], din}), rq drops the next cycle, go to LD_REL.
- LD_REL:
  - rq=0; wait for rdy=0. This is four-phase: no new rq while rdy is high.
  - If the counter reaches HDR_BITS/BUS_W: pulse hdr_valid for one cycle and go to WAIT_HASH. Otherwise go to LD_REQ.
- WAIT_HASH: on hash_valid, capture hash_in into the output shift register, go to UL_REQ.
- UL_REQ:
  - done=1, rq=1, dout = top BUS_W bits of the shift register.
  - When rdy=1: shift left by BUS_W, go to UL_REL.
- UL_REL:
  - done=1, rq=0; wait for rdy=0.
  - After HASH_BITS/BUS_W beats: done=0, go to IDLE. Otherwise go to UL_REQ.
- Latency: rq rises the cycle after start is sampled; rdy->rq fall is 1 cycle; rdy fall->next rq is 1 cycle.
- dout is stable from rq rise until the rdy sample.
- start asserted outside IDLE: ignored.
- hash_valid outside WAIT_HASH: ignored.
- abort in any non-IDLE state: next cycle rq=0, done=0, pulse err, go to IDLE. Partial hdr is retained but hdr_valid is not pulsed. abort wins over a simultaneous rdy.
- rst mid-operation: immediately returns to reset values, regardless of the handshake phase.
- Counter width: clog2(max(HDR_BITS,HASH_BITS)/BUS_W)+1; no wrap within a job.

Optional Feature:
- Macro: HS_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in LD_REQ, LD_REL, UL_REQ and UL_REL; it clears on each state transition.
  - On reaching TIMEOUT_CYC it behaves exactly as abort (err pulse, IDLE).
- Undefined: the counter is absent, and the block waits indefinitely on rdy.

Decomposition:
- Package hs_io_pkg:
  - state enum hs_state_t;
  - localparams for beat-count helpers (HDR_BEATS, HASH_BEATS, CNT_W function);
  - default TIMEOUT_CYC.
- One sub-module, hs_beat_port: owns the rq/rdy four-phase REQ/REL sequencing and the optional watchdog. It exposes beat_go, beat_ack and timeout to the parent FSM.

Test Plan:
- BUS_W=8: start, then a host model feeding the genesis header 0100…1DAC2B7C -> exactly 80 rq/rdy beats; hdr_valid pulses once; hdr equals the header; done=0 throughout.
- Then hash_valid with hash_in=256'h6FE28C0A…(genesis double-SHA) -> done rises; 32 beats; bytes 6F,E2,8C,0A… in order; done falls after the 32nd rdy release.
- BUS_W=32, same header -> 20 load beats and 8 unload beats; words match the header/hash slices MSB-first.
- abort asserted on load beat 40 together with rdy=1 -> err pulses once, rq=0 next cycle, no hdr_valid; a new start completes normally.
- Host holds rdy=1 across two cycles after the ack -> no second rq until rdy=0; beat count is unchanged.
- HS_WATCHDOG_EN with TIMEOUT_CYC=16 and host silent after beat 5 -> err pulses 16 cycles after the rq rise; state is IDLE. With the macro undefined, rq stays high for at least 100 cycles.
